// File: rtl/seven_seg_pkg.sv
// Constants and types shared by the seven-segment decoder and reader.
// Segment encodings are active-low, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seven_seg_pattern_to_bcd.sv
// Maps an active-low segment pattern back to {bcd, blank, err}.
// Latency: purely combinational.
// Backpressure: none.
module seven_seg_pattern_to_bcd
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       blank,
    output logic       err
);

    always_comb begin
        bcd   = 4'hF;
        blank = 1'b0;
        err   = 1'b0;
        case (pattern)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: begin
                bcd   = 4'd0;
                blank = 1'b1;
            end
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Reassembles a multiplexed seven-segment scan into a frame of BCD digits.
// Latency: digit accepted STABLE edges after a pin change; frame_valid one edge after the last digit.
// Backpressure: none; the display bus is observed passively.
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_n,
    input  logic [DIGITS-1:0]   an_n,
    output logic [4*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]   blank,
    output logic [DIGITS-1:0]   err,
    output logic                frame_valid,
    output logic                sync_err
);

    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(STABLE);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [6:0]          s_seg;
    logic [DIGITS-1:0]   s_an;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic                acc_flag;
    logic                same;
    logic                one_hot;
    logic                acc;
    logic [IW-1:0]       dig_idx;

    logic [3:0]          d_bcd;
    logic                d_blank;
    logic                d_err;

    state_t              state;
    state_t              state_nxt;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_nxt;
    logic                store;
    logic                sync_set;
    logic                upd;
    logic                sync_hit;

    logic [4*DIGITS-1:0] sh_bcd;
    logic [DIGITS-1:0]   sh_blank;
    logic [DIGITS-1:0]   sh_err;

    // The incoming sample is compared with S as it is registered, so the
    // counter reflects how many consecutive samples equal the newest one.
    assign same = (seg_n == s_seg) && (an_n == s_an);

    always_comb begin
        cnt_nxt = '0;
        if (same) begin
            cnt_nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
        end
    end

    always_comb begin : find_digit
        int nz;
        nz      = 0;
        dig_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!s_an[k]) begin
                nz      = nz + 1;
                dig_idx = IW'(k);
            end
        end
        one_hot = (nz == 1);
    end

    assign acc = same && (cnt_nxt == CNT_MAX) && one_hot && !acc_flag;

    seven_seg_pattern_to_bcd u_decode (
        .pattern (s_seg),
        .bcd     (d_bcd),
        .blank   (d_blank),
        .err     (d_err)
    );

    // Idle bus value on reset so the first driven digit always counts as a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg    <= SEG_BLANK;
            s_an     <= '1;
            cnt      <= '0;
            acc_flag <= 1'b0;
        end else begin
            s_seg    <= seg_n;
            s_an     <= an_n;
            cnt      <= cnt_nxt;
            acc_flag <= same && (acc_flag || acc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        store     = 1'b0;
        sync_set  = 1'b0;
        case (state)
            HUNT: begin
                if (acc && dig_idx == '0) begin
                    store     = 1'b1;
                    idx_nxt   = IW'(1);
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (acc) begin
                    if (dig_idx == idx) begin
                        store = 1'b1;
                        if (idx == IDX_LAST) begin
                            idx_nxt   = '0;
                            state_nxt = DONE;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else begin
                        sync_set = 1'b1;
                        if (dig_idx == '0) begin
                            store   = 1'b1;
                            idx_nxt = IW'(1);
                        end else begin
                            idx_nxt   = '0;
                            state_nxt = HUNT;
                        end
                    end
                end
            end
            DONE:    state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    always_comb begin
        upd = (state == DONE);
    end

    // sync_err goes through sync_hit so it lands one edge after the acceptance,
    // aligned with how frame_valid follows the final acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_bcd      <= '0;
            sh_blank    <= '0;
            sh_err      <= '0;
            bcd         <= '0;
            blank       <= '0;
            err         <= '0;
            frame_valid <= 1'b0;
            sync_hit    <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                if (store && dig_idx == IW'(k)) begin
                    sh_bcd[4*k +: 4] <= d_bcd;
                    sh_blank[k]      <= d_blank;
                    sh_err[k]        <= d_err;
                end
            end
            if (upd) begin
                bcd   <= sh_bcd;
                blank <= sh_blank;
                err   <= sh_err;
            end
            frame_valid <= upd;
            sync_hit    <= sync_set;
            sync_err    <= sync_hit;
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader with a run-length/frame model checked every cycle.
module tb_seven_seg_reader;

    localparam int DIGITS = 4;
    localparam int STABLE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n = 4'hF;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        frame_valid;
    logic        sync_err;

    logic [6:0]  t_pat = 7'h7F;
    logic [3:0]  t_bcd;
    logic        t_blank;
    logic        t_err;

    always #5 clk = ~clk;

    seven_seg_reader #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .bcd         (bcd),
        .blank       (blank),
        .err         (err),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    seven_seg_pattern_to_bcd u_p2b (
        .pattern (t_pat),
        .bcd     (t_bcd),
        .blank   (t_blank),
        .err     (t_err)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    logic [6:0] digit_pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // {bcd, blank, err}
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        r = {4'hF, 1'b0, 1'b1};
        if (p == 7'h7F) r = {4'h0, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++)
            if (p == digit_pat[i]) r = {4'(i), 1'b0, 1'b0};
        return r;
    endfunction

    // Model: a run of identical samples is accepted when it reaches STABLE samples.
    int          cyc = 0;
    int          m_run = 0;
    logic [6:0]  m_last_seg;
    logic [3:0]  m_last_an;
    int          m_expect = -1;
    logic        m_done_pend = 1'b0;
    logic        m_se_pend = 1'b0;
    logic [5:0]  m_sh [DIGITS];
    int          m_k;
    int          m_nz;
    logic [15:0] exp_bcd = '0;
    logic [3:0]  exp_blank = '0;
    logic [3:0]  exp_err = '0;
    logic        exp_fv = 1'b0;
    logic        exp_se = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_run = 0; m_expect = -1; m_done_pend = 1'b0; m_se_pend = 1'b0;
            for (int i = 0; i < DIGITS; i++) m_sh[i] = '0;
            exp_bcd = '0; exp_blank = '0; exp_err = '0; exp_fv = 1'b0; exp_se = 1'b0;
        end else begin
            exp_fv = m_done_pend;
            exp_se = m_se_pend;
            if (m_done_pend) begin
                for (int i = 0; i < DIGITS; i++) begin
                    exp_bcd[4*i +: 4] = m_sh[i][5:2];
                    exp_blank[i]      = m_sh[i][1];
                    exp_err[i]        = m_sh[i][0];
                end
            end
            m_done_pend = 1'b0;
            m_se_pend   = 1'b0;
            if (m_run > 0 && seg_n == m_last_seg && an_n == m_last_an) m_run = m_run + 1;
            else begin
                m_run = 1; m_last_seg = seg_n; m_last_an = an_n;
            end
            m_nz = 0; m_k = 0;
            for (int i = 0; i < DIGITS; i++)
                if (!an_n[i]) begin m_nz++; m_k = i; end
            if (m_run == STABLE && m_nz == 1) begin
                if (m_expect < 0) begin
                    if (m_k == 0) begin m_sh[0] = decode(seg_n); m_expect = 1; end
                end else if (m_k == m_expect) begin
                    m_sh[m_k] = decode(seg_n);
                    m_expect++;
                    if (m_expect == DIGITS) begin m_done_pend = 1'b1; m_expect = -1; end
                end else begin
                    m_se_pend = 1'b1;
                    if (m_k == 0) begin
                        for (int i = 0; i < DIGITS; i++) m_sh[i] = '0;
                        m_sh[0] = decode(seg_n);
                        m_expect = 1;
                    end else m_expect = -1;
                end
            end
        end
    end

    int fv_count = 0;
    int se_count = 0;
    int fv_cyc = -1;
    int se_cyc = -1;

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("bcd", bcd, exp_bcd);
            check("blank", blank, exp_blank);
            check("err", err, exp_err);
            check("frame_valid", frame_valid, exp_fv);
            check("sync_err", sync_err, exp_se);
            if (frame_valid === 1'b1) begin fv_count++; fv_cyc = cyc; end
            if (sync_err === 1'b1) begin se_count++; se_cyc = cyc; end
        end
    end

    int chg_cyc = 0;

    task automatic hold(input logic [6:0] p, input int d, input int n);
        seg_n   = p;
        an_n    = ~(4'b0001 << d);
        chg_cyc = cyc;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        seg_n = 7'h7F;
        an_n  = 4'hF;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic frame4(input logic [6:0] p0, input logic [6:0] p1,
                          input logic [6:0] p2, input logic [6:0] p3);
        hold(p0, 0, 5);
        hold(p1, 1, 5);
        hold(p2, 2, 5);
        hold(p3, 3, 5);
    endtask

    task automatic check_out(input string name, input logic [15:0] b,
                             input logic [3:0] bl, input logic [3:0] er);
        check({name, "_bcd"}, bcd, b);
        check({name, "_blank"}, blank, bl);
        check({name, "_err"}, err, er);
        check({name, "_model_bcd"}, exp_bcd, b);
    endtask

    logic [6:0] tp [12] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                            7'h02, 7'h78, 7'h00, 7'h10, 7'h7F, 7'h7E};
    logic [5:0] te [12] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14,
                            6'h18, 6'h1C, 6'h20, 6'h24, 6'h02, 6'h3D};

    int fvb;
    int seb;

    initial begin
        for (int i = 0; i < 12; i++) begin
            t_pat = tp[i];
            #1;
            check("p2b", {t_bcd, t_blank, t_err}, te[i]);
        end

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        check_out("reset", 16'h0000, 4'h0, 4'h0);
        check("reset_fv", frame_valid, 1'b0);
        check("reset_se", sync_err, 1'b0);

        fvb = fv_count;
        frame4(7'h24, 7'h30, 7'h19, 7'h40);
        check("clean_fv_count", fv_count - fvb, 1);
        check("clean_latency", fv_cyc - chg_cyc, STABLE + 1);
        check_out("clean", 16'h0432, 4'h0, 4'h0);
        idle(2);

        frame4(7'h40, 7'h7F, 7'h7E, 7'h40);
        check_out("blankinv", 16'h0F00, 4'b0010, 4'b0100);

        hold(7'h79, 0, 2);
        hold(7'h40, 0, 5);
        hold(7'h79, 1, 5);
        hold(7'h24, 2, 5);
        hold(7'h30, 3, 5);
        check_out("glitch", 16'h3210, 4'h0, 4'h0);

        fvb = fv_count;
        seb = se_count;
        hold(7'h40, 0, 5);
        hold(7'h79, 1, 5);
        hold(7'h30, 3, 5);
        check("ooo_se_count", se_count - seb, 1);
        check("ooo_se_latency", se_cyc - chg_cyc, STABLE + 1);
        check("ooo_fv_count", fv_count - fvb, 0);
        check_out("ooo_hold", 16'h3210, 4'h0, 4'h0);
        frame4(7'h19, 7'h12, 7'h02, 7'h78);
        check_out("ooo_next", 16'h7654, 4'h0, 4'h0);
        check("ooo_next_fv", fv_count - fvb, 1);

        seb = se_count;
        hold(7'h10, 0, 5);
        hold(7'h00, 1, 5);
        hold(7'h02, 0, 5);
        hold(7'h12, 1, 5);
        hold(7'h19, 2, 5);
        hold(7'h30, 3, 5);
        check("restart_se_count", se_count - seb, 1);
        check_out("restart", 16'h3456, 4'h0, 4'h0);
        idle(2);

        hold(7'h40, 0, 5);
        hold(7'h79, 1, 3);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check_out("midreset", 16'h0000, 4'h0, 4'h0);
        fvb = fv_count;
        hold(7'h24, 2, 5);
        hold(7'h30, 3, 5);
        check("midreset_no_fv", fv_count - fvb, 0);
        frame4(7'h30, 7'h19, 7'h12, 7'h02);
        check("midreset_fv", fv_count - fvb, 1);
        check_out("midreset_next", 16'h6543, 4'h0, 4'h0);
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, expected completion earlier");
        $fatal(1);
    end

endmodule
